// File: rtl/lsu_pkg.sv
// Shared LSU definitions: memory command codes, byte-lane selects and the
// load-return entry layout used by the LSU datapath and the return buffer.
package lsu_pkg;

    localparam logic CMD_LOAD  = 1'b0;
    localparam logic CMD_STORE = 1'b1;

    // Lane select is {be1, be0}
    typedef enum logic [1:0] {
        LANE_NONE = 2'b00,
        LANE_LO   = 2'b01,
        LANE_HI   = 2'b10,
        LANE_WORD = 2'b11
    } lane_sel_e;

    localparam int RET_W = 18;

    typedef struct packed {
        logic [15:0] data;
        logic        is_byte;
        logic        t_id;
    } ret_entry_t;

    function automatic ret_entry_t align_load(input logic [1:0]  lanes,
                                              input logic [15:0] rdata,
                                              input logic        tid);
        ret_entry_t e;
        e.t_id = tid;
        case (lane_sel_e'(lanes))
            LANE_WORD: begin
                e.data    = rdata;
                e.is_byte = 1'b0;
            end
            LANE_LO: begin
                e.data    = {8'h00, rdata[7:0]};
                e.is_byte = 1'b1;
            end
            LANE_HI: begin
                e.data    = {8'h00, rdata[15:8]};
                e.is_byte = 1'b1;
            end
            LANE_NONE: begin
                e.data    = 16'h0000;
                e.is_byte = 1'b1;
            end
            default: begin
                e.data    = 16'h0000;
                e.is_byte = 1'b1;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lsu_ret_fifo.sv
// Load-return FIFO: DEPTH entries of W bits, pointers wrap modulo DEPTH.
// A push on a full FIFO is accepted only when a pop happens on the same edge.
module lsu_ret_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = RET_W
) (
    input  logic         clk,
    input  logic         a_rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign full  = (count_r == CNT_MAX);
    assign empty = (count_r == {CNT_W{1'b0}});
    assign head  = mem_r[rd_ptr_r];

    // Qualify requests: pop needs data, push needs room unless a pop frees it
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (pop && !empty) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (push && (!full || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Entry storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/lsu_load_return.sv
// LSU load-return path: captures completed loads, aligns the selected byte
// lanes, buffers them for writeback and flags loads dropped on a full buffer.
module lsu_load_return
    import lsu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        mem_bus_assert,
    input  logic        mem_rdy,
    input  logic        mem_cmd,
    input  logic        be0,
    input  logic        be1,
    input  logic        t_id,
    input  logic [15:0] mem_rdata,
    output logic        ld_space,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic        wb_byte,
    output logic        wb_t_id,
    input  logic        wb_ready,
    output logic        ovf
);

    logic       capture_s;
    logic       pop_s;
    logic       full_s;
    logic       empty_s;
    ret_entry_t cap_entry_s;
    ret_entry_t head_s;
    logic       ovf_r;

    // Capture decode and lane alignment of the completing load
    always_comb begin
        capture_s   = mem_bus_assert & mem_rdy & (mem_cmd == CMD_LOAD);
        cap_entry_s = align_load({be1, be0}, mem_rdata, t_id);
    end

    assign pop_s = ~empty_s & wb_ready;

    lsu_ret_fifo #(
        .DEPTH (DEPTH),
        .W     (RET_W)
    ) u_fifo (
        .clk   (clk),
        .a_rst (a_rst),
        .push  (capture_s),
        .pop   (pop_s),
        .din   (cap_entry_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    // Sticky overflow: a load arrived with no room and nothing leaving
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            ovf_r <= 1'b0;
        end else if (capture_s && full_s && !pop_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ld_space = ~full_s;
    assign wb_valid = ~empty_s;
    assign wb_data  = head_s.data;
    assign wb_byte  = head_s.is_byte;
    assign wb_t_id  = head_s.t_id;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_lsu_load_return.sv
// Directed bench for lsu_load_return (DEPTH = 2): alignment, ordering,
// back-pressure, overflow, full push+pop and asynchronous reset.
module tb_lsu_load_return;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        mem_bus_assert;
    logic        mem_rdy;
    logic        mem_cmd;
    logic        be0;
    logic        be1;
    logic        t_id;
    logic [15:0] mem_rdata;
    logic        ld_space;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        wb_byte;
    logic        wb_t_id;
    logic        wb_ready;
    logic        ovf;

    int pass_cnt = 0;
    int total_cnt = 0;

    lsu_load_return #(.DEPTH(2)) dut (
        .clk            (clk),
        .a_rst          (a_rst),
        .mem_bus_assert (mem_bus_assert),
        .mem_rdy        (mem_rdy),
        .mem_cmd        (mem_cmd),
        .be0            (be0),
        .be1            (be1),
        .t_id           (t_id),
        .mem_rdata      (mem_rdata),
        .ld_space       (ld_space),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_byte        (wb_byte),
        .wb_t_id        (wb_t_id),
        .wb_ready       (wb_ready),
        .ovf            (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One full clock: capture edge, then return to the sampling (falling) edge
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_load(input logic b1, input logic b0, input logic [15:0] d, input logic id);
        mem_bus_assert = 1'b1;
        mem_rdy        = 1'b1;
        mem_cmd        = CMD_LOAD;
        be1            = b1;
        be0            = b0;
        mem_rdata      = d;
        t_id           = id;
    endtask

    task automatic idle_bus();
        mem_bus_assert = 1'b0;
        mem_rdy        = 1'b0;
        mem_cmd        = CMD_LOAD;
        be1            = 1'b0;
        be0            = 1'b0;
        mem_rdata      = 16'h0000;
        t_id           = 1'b0;
    endtask

    task automatic load(input logic b1, input logic b0, input logic [15:0] d, input logic id);
        drive_load(b1, b0, d, id);
        cycle();
        idle_bus();
    endtask

    task automatic pop_one();
        wb_ready = 1'b1;
        cycle();
        wb_ready = 1'b0;
    endtask

    initial begin
        a_rst    = 1'b1;
        wb_ready = 1'b0;
        idle_bus();
        #12;
        chk("rst_valid", {15'd0, wb_valid}, 16'd0);
        chk("rst_space", {15'd0, ld_space}, 16'd1);
        chk("rst_ovf",   {15'd0, ovf},      16'd0);
        @(negedge clk);
        a_rst = 1'b0;
        cycle();

        // Word load, one-cycle latency
        drive_load(1'b1, 1'b1, 16'hBEEF, 1'b1);
        #1;
        chk("word_no_bypass", {15'd0, wb_valid}, 16'd0);
        @(negedge clk);
        idle_bus();
        chk("word_valid", {15'd0, wb_valid}, 16'd1);
        chk("word_data",  wb_data,           16'hBEEF);
        chk("word_byte",  {15'd0, wb_byte},  16'd0);
        chk("word_tid",   {15'd0, wb_t_id},  16'd1);
        pop_one();
        chk("word_popped", {15'd0, wb_valid}, 16'd0);

        // Byte lane alignment
        load(1'b1, 1'b0, 16'hA55A, 1'b0);
        chk("hi_data", wb_data,          16'h00A5);
        chk("hi_byte", {15'd0, wb_byte}, 16'd1);
        chk("hi_tid",  {15'd0, wb_t_id}, 16'd0);
        pop_one();
        load(1'b0, 1'b1, 16'hA55A, 1'b1);
        chk("lo_data", wb_data,          16'h005A);
        chk("lo_byte", {15'd0, wb_byte}, 16'd1);
        pop_one();
        load(1'b0, 1'b0, 16'hFFFF, 1'b0);
        chk("none_valid", {15'd0, wb_valid}, 16'd1);
        chk("none_data",  wb_data,           16'h0000);
        chk("none_byte",  {15'd0, wb_byte},  16'd1);
        pop_one();

        // Store completion is ignored; wb_ready on empty does nothing
        drive_load(1'b1, 1'b1, 16'h1234, 1'b1);
        mem_cmd  = CMD_STORE;
        wb_ready = 1'b1;
        cycle();
        idle_bus();
        wb_ready = 1'b0;
        chk("store_valid", {15'd0, wb_valid}, 16'd0);
        chk("store_space", {15'd0, ld_space}, 16'd1);

        // Back-pressure and overflow
        drive_load(1'b1, 1'b1, 16'h1111, 1'b0);
        cycle();
        drive_load(1'b1, 1'b1, 16'h2222, 1'b1);
        cycle();
        idle_bus();
        chk("bp_space", {15'd0, ld_space}, 16'd0);
        chk("bp_head",  wb_data,           16'h1111);
        chk("bp_ovf0",  {15'd0, ovf},      16'd0);
        load(1'b1, 1'b1, 16'h3333, 1'b0);
        chk("bp_ovf1",   {15'd0, ovf}, 16'd1);
        chk("bp_stable", wb_data,      16'h1111);
        chk("bp_tid0",   {15'd0, wb_t_id}, 16'd0);
        pop_one();
        chk("bp_second", wb_data,          16'h2222);
        chk("bp_tid1",   {15'd0, wb_t_id}, 16'd1);
        pop_one();
        chk("bp_drained", {15'd0, wb_valid}, 16'd0);
        chk("bp_space1",  {15'd0, ld_space}, 16'd1);
        chk("ovf_sticky", {15'd0, ovf},      16'd1);

        // Asynchronous reset with two entries buffered
        load(1'b1, 1'b1, 16'h5555, 1'b0);
        load(1'b1, 1'b1, 16'h6666, 1'b1);
        chk("ar_full", {15'd0, ld_space}, 16'd0);
        #1;
        a_rst = 1'b1;
        #1;
        chk("ar_valid", {15'd0, wb_valid}, 16'd0);
        chk("ar_space", {15'd0, ld_space}, 16'd1);
        chk("ar_ovf",   {15'd0, ovf},      16'd0);
        a_rst = 1'b0;
        @(negedge clk);
        chk("ar_hold", {15'd0, wb_valid}, 16'd0);

        // Full with simultaneous push and pop
        load(1'b1, 1'b1, 16'h7777, 1'b0);
        load(1'b1, 1'b1, 16'h8888, 1'b1);
        drive_load(1'b1, 1'b1, 16'h4444, 1'b0);
        wb_ready = 1'b1;
        cycle();
        idle_bus();
        chk("pp_count", {15'd0, ld_space}, 16'd0);
        chk("pp_ovf",   {15'd0, ovf},      16'd0);
        chk("pp_head",  wb_data,           16'h8888);
        cycle();
        chk("pp_last", wb_data, 16'h4444);
        cycle();
        wb_ready = 1'b0;
        chk("pp_empty", {15'd0, wb_valid}, 16'd0);
        chk("pp_ovf_end", {15'd0, ovf},    16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lsu_load_return.md
LSU_LOAD_RETURN -- requirements
Module: lsu_load_return

Interface
REQ-001 Parameter DEPTH, default 2, load-return FIFO entries; SHALL be a power of two and at least 2.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 a_rst  in  1  reset, asynchronous, active-high.
REQ-004 mem_bus_assert  in  1  LSU holds the memory bus; a transaction is in flight.
REQ-005 mem_rdy  in  1  memory completes the in-flight transaction this cycle.
REQ-006 mem_cmd  in  1  command of the in-flight transaction; 0 = load, 1 = store.
REQ-007 be0  in  1  low byte lane enable of the in-flight transaction.
REQ-008 be1  in  1  high byte lane enable of the in-flight transaction.
REQ-009 t_id  in  1  transaction id of the in-flight transaction.
REQ-010 mem_rdata  in  16  read data from memory; valid when mem_rdy is high.
REQ-011 ld_space  out  1  at least one free FIFO entry; the LSU issue logic SHALL NOT start a load while this is low.
REQ-012 wb_valid  out  1  head entry valid toward writeback.
REQ-013 wb_data  out  16  aligned load result at the head entry.
REQ-014 wb_byte  out  1  head entry is a byte load (upper 8 bits are zero).
REQ-015 wb_t_id  out  1  transaction id of the head entry.
REQ-016 wb_ready  in  1  writeback consumes the head entry when wb_valid and wb_ready are both high.
REQ-017 ovf  out  1  sticky error: a load completed while the FIFO was full.

Function
REQ-018 Capture event = mem_bus_assert & mem_rdy & ~mem_cmd, sampled at the rising edge; store completions SHALL be ignored.
REQ-019 Alignment on capture: be0&be1 -> data = mem_rdata, byte = 0; be0 only -> data = {8'h00, mem_rdata[7:0]}, byte = 1; be1 only -> data = {8'h00, mem_rdata[15:8]}, byte = 1.
REQ-020 A capture event with be0 = be1 = 0 SHALL still push an entry: data = 16'h0000, byte = 1.
REQ-021 The pushed entry SHALL hold aligned data, byte flag and t_id.
REQ-022 Latency: wb_valid SHALL rise in the cycle after the capture edge into an empty FIFO; there is no combinational bypass from mem_rdata to wb_data.
REQ-023 wb_data, wb_byte and wb_t_id SHALL reflect the head entry and SHALL remain stable while wb_valid = 1 and wb_ready = 0.
REQ-024 A pop occurs on an edge where wb_valid & wb_ready; entries SHALL leave in capture order.
REQ-025 Push and pop on the same edge SHALL both take effect and leave the count unchanged; this includes the full case, where the push is accepted.
REQ-026 A push when count = DEPTH with no simultaneous pop SHALL drop the data, leave the FIFO unchanged and set ovf.
REQ-027 ovf SHALL stay set until reset.
REQ-028 ld_space = (count < DEPTH), registered-state derived, with no combinational path from wb_ready.
REQ-029 wb_valid = (count != 0).
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 count SHALL be log2(DEPTH)+1 bits wide and SHALL never exceed DEPTH.
REQ-032 wb_ready when wb_valid = 0 SHALL have no effect.

Reset
REQ-033 a_rst high SHALL immediately clear the pointers, count and ovf, giving wb_valid = 0, ld_space = 1, ovf = 0, regardless of the clock.
REQ-034 Reset mid-operation SHALL discard all buffered entries; a capture event coincident with the reset assertion is lost.
REQ-035 FIFO data storage SHALL NOT be reset; while wb_valid = 0, wb_data, wb_byte and wb_t_id are don't-care.

Structure
REQ-036 Shared package lsu_pkg SHALL hold CMD_LOAD = 1'b0, CMD_STORE = 1'b1, and the lane-select encodings used by lsu_16b and this block.
REQ-037 Top-level logic SHALL be capture decode, the alignment mux and the ovf flag.
REQ-038 Buffering SHALL be one sub-module, lsu_ret_fifo: parameterised DEPTH and width 18 (data, byte, t_id), exposing push, pop, full, empty and head.

Verification
REQ-039 Word load: be0 = 1, be1 = 1, mem_rdata = 16'hBEEF, t_id = 1, mem_rdy pulse -> next cycle wb_valid = 1, wb_data = 16'hBEEF, wb_byte = 0, wb_t_id = 1.
REQ-040 High-byte load: be0 = 0, be1 = 1, mem_rdata = 16'hA55A -> wb_data = 16'h00A5, wb_byte = 1; low-byte load of the same data -> wb_data = 16'h005A.
REQ-041 Store ignored: mem_cmd = 1, mem_rdy = 1, mem_bus_assert = 1 -> wb_valid stays 0 and count stays 0.
REQ-042 Back-pressure with DEPTH = 2: loads 16'h1111, 16'h2222 with wb_ready = 0 -> ld_space = 0; a third load 16'h3333 -> ovf = 1; release wb_ready -> 16'h1111 then 16'h2222, then wb_valid = 0.
REQ-043 Full with simultaneous push and pop: FIFO full, wb_ready = 1, load 16'h4444 on the same edge -> count stays 2, ovf stays 0, 16'h4444 is delivered last.
REQ-044 Async reset: FIFO holding 2 entries, assert a_rst between clock edges -> wb_valid = 0, ld_space = 1, ovf = 0 without a clock edge.
